// File: rtl/slc_cfg_pkg.sv
// Shared types and constants for the AP3 super logic cell config loader.
// Control-byte bit positions match the logic cell parameter mapping.
package slc_cfg_pkg;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK,
    COMMIT
  } cfg_state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  localparam int LUT_W        = 16;
  localparam int SEL_W        = 2;
  localparam int BYTES_PER_LC = 3;

  localparam int MODE_LSB = 0;
  localparam int QDI_LSB  = 2;
  localparam int BQZ_LSB  = 4;
  localparam int CQZ_LSB  = 6;

endpackage

// File: rtl/slc_config_loader_if.sv
// Byte-wide configuration stream with valid/ready handshake and abort.
// Master drives bytes; the loader is the slave.
interface slc_config_loader_if;

  logic [7:0] DI;
  logic       DI_VLD;
  logic       DI_RDY;
  logic       CFG_ABORT;

  modport master (
    output DI,
    output DI_VLD,
    output CFG_ABORT,
    input  DI_RDY
  );

  modport slave (
    input  DI,
    input  DI_VLD,
    input  CFG_ABORT,
    output DI_RDY
  );

endinterface

// File: rtl/slc_cfg_watchdog.sv
// Idle-cycle counter; expired holds once TIMEOUT idle cycles are seen.
// Saturates so a late clear is never missed.
module slc_cfg_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TIMEOUT));

  // Count idle cycles, clear on any transfer or outside a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/slc_config_loader.sv
// Frame parser with shadow/active config registers for NUM_LC cells.
// Outputs change only on a verified commit, never mid-frame.
module slc_config_loader
  import slc_cfg_pkg::*;
#(
  parameter int         NUM_LC    = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int         TIMEOUT   = 255
) (
  input  logic                      QCK,
  input  logic                      QRT,
  slc_config_loader_if.slave        bus,
  output logic [LUT_W*NUM_LC-1:0]   LC_LUT,
  output logic [SEL_W*NUM_LC-1:0]   LC_MODE,
  output logic [SEL_W*NUM_LC-1:0]   LC_QDI_MUX,
  output logic [SEL_W*NUM_LC-1:0]   LC_BQZ_MUX,
  output logic [SEL_W*NUM_LC-1:0]   LC_CQZ_MUX,
  output logic                      CFG_VALID,
  output logic                      DONE,
  output logic                      ERR
);

  localparam int NB   = BYTES_PER_LC * NUM_LC;
  localparam int IW   = $clog2(NB);
  localparam int LAST = NB - 1;

  cfg_state_e    state, state_n;
  logic          rdy_en;
  logic          xfer;
  logic          in_frame;
  logic          expired;
  logic          stop;
  logic          err_n;
  logic          wr;
  logic          commit;
  logic [IW-1:0] idx;
  logic [7:0]    acc;
  logic [7:0]    sh [NB];

  assign in_frame   = (state == PAYLOAD) || (state == CHECK);
  assign bus.DI_RDY = rdy_en && (state != COMMIT);
  assign xfer       = bus.DI_VLD && bus.DI_RDY;
  assign stop       = bus.CFG_ABORT || expired;

  slc_cfg_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (QCK),
    .rst_n   (QRT),
    .clr     (xfer || !in_frame),
    .en      (in_frame),
    .expired (expired)
  );

  // Hold off ready for the first cycle out of reset
  always_ff @(posedge QCK or negedge QRT) begin
    if (!QRT) rdy_en <= 1'b0;
    else      rdy_en <= 1'b1;
  end

  // State register
  always_ff @(posedge QCK or negedge QRT) begin
    if (!QRT) state <= HUNT;
    else      state <= state_n;
  end

  // Next state; abort/timeout take priority over a same-edge byte
  always_comb begin
    state_n = state;
    err_n   = 1'b0;
    wr      = 1'b0;
    commit  = 1'b0;
    unique case (state)
      HUNT: begin
        if (xfer && bus.DI == SYNC_BYTE) state_n = PAYLOAD;
      end
      PAYLOAD: begin
        if (stop) begin
          state_n = HUNT;
          err_n   = 1'b1;
        end else if (xfer) begin
          wr = 1'b1;
          if (idx == IW'(LAST)) state_n = CHECK;
        end
      end
      CHECK: begin
        if (stop) begin
          state_n = HUNT;
          err_n   = 1'b1;
        end else if (xfer) begin
          if (bus.DI == acc) begin
            state_n = COMMIT;
          end else begin
            state_n = HUNT;
            err_n   = 1'b1;
          end
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_n = HUNT;
      end
      default: state_n = HUNT;
    endcase
  end

  // Shadow capture, index and running checksum
  always_ff @(posedge QCK or negedge QRT) begin
    if (!QRT) begin
      idx <= '0;
      acc <= '0;
      for (int i = 0; i < NB; i++) sh[i] <= '0;
    end else if (state == HUNT) begin
      idx <= '0;
      acc <= '0;
    end else if (wr) begin
      sh[idx] <= bus.DI;
      acc     <= acc ^ bus.DI;
      idx     <= idx + 1'b1;
    end
  end

  // Active config and status pulses
  always_ff @(posedge QCK or negedge QRT) begin
    if (!QRT) begin
      LC_LUT     <= '0;
      LC_MODE    <= '0;
      LC_QDI_MUX <= '0;
      LC_BQZ_MUX <= '0;
      LC_CQZ_MUX <= '0;
      CFG_VALID  <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      DONE <= commit;
      ERR  <= err_n;
      if (commit) begin
        CFG_VALID <= 1'b1;
        for (int i = 0; i < NUM_LC; i++) begin
          LC_LUT[LUT_W*i +: LUT_W] <=
            {sh[BYTES_PER_LC*i+1], sh[BYTES_PER_LC*i]};
          LC_MODE[SEL_W*i +: SEL_W] <=
            sh[BYTES_PER_LC*i+2][MODE_LSB +: SEL_W];
          LC_QDI_MUX[SEL_W*i +: SEL_W] <=
            sh[BYTES_PER_LC*i+2][QDI_LSB +: SEL_W];
          LC_BQZ_MUX[SEL_W*i +: SEL_W] <=
            sh[BYTES_PER_LC*i+2][BQZ_LSB +: SEL_W];
          LC_CQZ_MUX[SEL_W*i +: SEL_W] <=
            sh[BYTES_PER_LC*i+2][CQZ_LSB +: SEL_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_slc_config_loader.sv
// Randomized frame bench for slc_config_loader with a frame-level model.
// Model tracks committed config per LC; outputs compared as one vector.
module tb_slc_config_loader;

  localparam int N  = 8;
  localparam int NB = 3 * N;
  localparam int TO = 255;
  localparam logic [7:0] SYNC = 8'hA5;

  logic QCK = 1'b0;
  logic QRT;

  always #5 QCK = ~QCK;

  slc_config_loader_if bus ();

  logic [16*N-1:0] LC_LUT;
  logic [2*N-1:0]  LC_MODE;
  logic [2*N-1:0]  LC_QDI_MUX;
  logic [2*N-1:0]  LC_BQZ_MUX;
  logic [2*N-1:0]  LC_CQZ_MUX;
  logic            CFG_VALID;
  logic            DONE;
  logic            ERR;

  slc_config_loader #(
    .NUM_LC    (N),
    .SYNC_BYTE (SYNC),
    .TIMEOUT   (TO)
  ) dut (
    .QCK        (QCK),
    .QRT        (QRT),
    .bus        (bus),
    .LC_LUT     (LC_LUT),
    .LC_MODE    (LC_MODE),
    .LC_QDI_MUX (LC_QDI_MUX),
    .LC_BQZ_MUX (LC_BQZ_MUX),
    .LC_CQZ_MUX (LC_CQZ_MUX),
    .CFG_VALID  (CFG_VALID),
    .DONE       (DONE),
    .ERR        (ERR)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int d0;
  int e0;
  time t_ck;

  logic [15:0] m_lut [N];
  logic [7:0]  m_ctl [N];
  logic        m_valid;
  logic [7:0]  pay [NB];

  logic [192:0] act_all;
  logic [192:0] old_all;

  assign act_all = {LC_LUT, LC_MODE, LC_QDI_MUX,
                    LC_BQZ_MUX, LC_CQZ_MUX, CFG_VALID};

  always @(negedge QCK) begin
    if (DONE === 1'b1) done_cnt++;
    if (ERR === 1'b1) err_cnt++;
  end

  function automatic logic [16*N-1:0] exp_lut();
    logic [16*N-1:0] r;
    for (int i = 0; i < N; i++) r[16*i +: 16] = m_lut[i];
    return r;
  endfunction

  function automatic logic [2*N-1:0] exp_sel(input int lsb);
    logic [2*N-1:0] r;
    for (int i = 0; i < N; i++) r[2*i +: 2] = m_ctl[i][lsb +: 2];
    return r;
  endfunction

  function automatic logic [192:0] exp_all();
    return {exp_lut(), exp_sel(0), exp_sel(2),
            exp_sel(4), exp_sel(6), m_valid};
  endfunction

  function automatic logic [7:0] csum();
    logic [7:0] c;
    c = 8'h00;
    for (int k = 0; k < NB; k++) c = c ^ pay[k];
    return c;
  endfunction

  task automatic model_commit();
    for (int i = 0; i < N; i++) begin
      m_lut[i] = {pay[3*i+1], pay[3*i]};
      m_ctl[i] = pay[3*i+2];
    end
    m_valid = 1'b1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_lut[i] = 16'h0;
      m_ctl[i] = 8'h0;
    end
    m_valid = 1'b0;
  endtask

  task automatic gen_random();
    for (int k = 0; k < NB; k++) pay[k] = 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge QCK);
    @(negedge QCK);
    n = 0;
    while (bus.DI_RDY !== 1'b1 && n < 20) begin
      @(negedge QCK);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL rdy_wait got DI_RDY=%b need 1", bus.DI_RDY);
    end
    bus.DI = b;
    bus.DI_VLD = 1'b1;
    @(posedge QCK);
    #1 bus.DI_VLD = 1'b0;
  endtask

  function automatic int rgap(input int maxgap);
    return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
  endfunction

  task automatic send_range(input int lo, input int hi,
                            input int maxgap);
    for (int k = lo; k <= hi; k++) send_byte(pay[k], rgap(maxgap));
  endtask

  task automatic send_body(input logic [7:0] mask, input int maxgap);
    send_range(0, NB - 1, maxgap);
    send_byte(csum() ^ mask, rgap(maxgap));
    t_ck = $time;
  endtask

  task automatic send_frame(input logic [7:0] mask, input int maxgap);
    send_byte(SYNC, rgap(maxgap));
    send_body(mask, maxgap);
  endtask

  task automatic test_reset();
    QRT = 1'b0;
    bus.DI = 8'h00;
    bus.DI_VLD = 1'b0;
    bus.CFG_ABORT = 1'b0;
    model_clear();
    repeat (3) @(negedge QCK);
    checks++;
    if (act_all !== exp_all()) begin
      errors++;
      $display("FAIL reset_cfg got %h need %h", act_all, exp_all());
    end
    checks++;
    if ({DONE, ERR, bus.DI_RDY} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b need 000",
               {DONE, ERR, bus.DI_RDY});
    end
    @(posedge QCK);
    #1 QRT = 1'b1;
    @(negedge QCK);
    checks++;
    if (bus.DI_RDY !== 1'b0) begin
      errors++;
      $display("FAIL rdy_first_cycle got %b need 0", bus.DI_RDY);
    end
    @(negedge QCK);
    checks++;
    if (bus.DI_RDY !== 1'b1) begin
      errors++;
      $display("FAIL rdy_after_reset got %b need 1", bus.DI_RDY);
    end
  endtask

  task automatic test_valid_frame();
    for (int i = 0; i < N; i++) begin
      logic [15:0] l;
      l = 16'h1111 * 16'(i);
      pay[3*i]   = l[7:0];
      pay[3*i+1] = l[15:8];
      pay[3*i+2] = 8'hE4;
    end
    d0 = done_cnt;
    e0 = err_cnt;
    old_all = exp_all();
    send_frame(8'h00, 0);
    @(negedge QCK);
    checks++;
    if (bus.DI_RDY !== 1'b0 || act_all !== old_all) begin
      errors++;
      $display("FAIL commit_cycle got rdy=%b cfg=%h need 0 %h",
               bus.DI_RDY, act_all, old_all);
    end
    model_commit();
    @(negedge QCK);
    checks++;
    if (DONE !== 1'b1) begin
      errors++;
      $display("FAIL done_latency got %b need 1", DONE);
    end
    checks++;
    if (act_all !== exp_all()) begin
      errors++;
      $display("FAIL valid_cfg got %h need %h", act_all, exp_all());
    end
    checks++;
    if ({LC_LUT[31:16], LC_MODE[1:0], LC_QDI_MUX[1:0],
         LC_BQZ_MUX[1:0], LC_CQZ_MUX[1:0], CFG_VALID}
        !== {16'h1111, 2'b00, 2'b01, 2'b10, 2'b11, 1'b1}) begin
      errors++;
      $display("FAIL lc1_fields got %h %b %b %b %b %b",
               LC_LUT[31:16], LC_MODE[1:0], LC_QDI_MUX[1:0],
               LC_BQZ_MUX[1:0], LC_CQZ_MUX[1:0], CFG_VALID);
    end
    @(negedge QCK);
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL valid_pulses got done=%0d err=%0d need 1 0",
               done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_bad_checksum();
    gen_random();
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(8'h01, 2);
    repeat (4) @(negedge QCK);
    checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL badck_pulses got done=%0d err=%0d need 0 1",
               done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if (act_all !== exp_all()) begin
      errors++;
      $display("FAIL badck_cfg got %h need %h", act_all, exp_all());
    end
  endtask

  task automatic test_garbage();
    logic [7:0] g;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'h00, rgap(3));
    send_byte(8'hFF, rgap(3));
    for (int k = 0; k < 4; k++) begin
      g = 8'($urandom);
      if (g == SYNC) g = 8'h5A;
      send_byte(g, rgap(3));
    end
    gen_random();
    send_frame(8'h00, 3);
    model_commit();
    repeat (3) @(negedge QCK);
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL garbage_pulses got done=%0d err=%0d need 1 0",
               done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if (act_all !== exp_all()) begin
      errors++;
      $display("FAIL garbage_cfg got %h need %h", act_all, exp_all());
    end
  endtask

  task automatic test_timeout();
    gen_random();
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(SYNC, 0);
    send_range(0, 10, 0);
    repeat (100) @(negedge QCK);
    send_range(11, NB - 1, 0);
    send_byte(csum(), 0);
    model_commit();
    repeat (3) @(negedge QCK);
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL short_stall got done=%0d err=%0d need 1 0",
               done_cnt - d0, err_cnt - e0);
    end
    gen_random();
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(SYNC, 0);
    send_range(0, 10, 0);
    repeat (TO + 10) @(negedge QCK);
    checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL timeout_pulses got done=%0d err=%0d need 0 1",
               done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if (act_all !== exp_all()) begin
      errors++;
      $display("FAIL timeout_cfg got %h need %h", act_all, exp_all());
    end
    gen_random();
    send_frame(8'h00, 1);
    model_commit();
    repeat (3) @(negedge QCK);
    checks++;
    if (act_all !== exp_all() || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL after_timeout got %h done=%0d need %h 1",
               act_all, done_cnt - d0, exp_all());
    end
  endtask

  task automatic test_abort();
    gen_random();
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(SYNC, 0);
    send_range(0, 4, 1);
    @(negedge QCK);
    bus.DI = pay[5];
    bus.DI_VLD = 1'b1;
    bus.CFG_ABORT = 1'b1;
    @(posedge QCK);
    #1;
    bus.DI_VLD = 1'b0;
    bus.CFG_ABORT = 1'b0;
    repeat (3) @(negedge QCK);
    checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL abort_pulses got done=%0d err=%0d need 0 1",
               done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if (act_all !== exp_all()) begin
      errors++;
      $display("FAIL abort_cfg got %h need %h", act_all, exp_all());
    end
    bus.CFG_ABORT = 1'b1;
    repeat (3) @(negedge QCK);
    bus.CFG_ABORT = 1'b0;
    @(negedge QCK);
    checks++;
    if (err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL abort_hunt got err=%0d need 1", err_cnt - e0);
    end
    gen_random();
    send_frame(8'h00, 2);
    model_commit();
    repeat (3) @(negedge QCK);
    checks++;
    if (act_all !== exp_all() || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL after_abort got %h done=%0d need %h 1",
               act_all, done_cnt - d0, exp_all());
    end
  endtask

  task automatic test_back_to_back();
    time t_sync;
    d0 = done_cnt;
    e0 = err_cnt;
    gen_random();
    pay[3] = SYNC;
    pay[10] = SYNC;
    send_frame(8'h00, 0);
    model_commit();
    gen_random();
    send_byte(SYNC, 0);
    t_sync = $time;
    checks++;
    if (t_sync - t_ck !== 20) begin
      errors++;
      $display("FAIL b2b_sync_gap got %0t need 20", t_sync - t_ck);
    end
    send_body(8'h00, 0);
    model_commit();
    repeat (3) @(negedge QCK);
    checks++;
    if (done_cnt - d0 !== 2 || err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL b2b_pulses got done=%0d err=%0d need 2 0",
               done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if (act_all !== exp_all()) begin
      errors++;
      $display("FAIL b2b_cfg got %h need %h", act_all, exp_all());
    end
  endtask

  task automatic test_reset_mid();
    gen_random();
    send_byte(SYNC, 0);
    send_range(0, 7, 0);
    #2 QRT = 1'b0;
    model_clear();
    #1;
    checks++;
    if (act_all !== exp_all() || bus.DI_RDY !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got %h rdy=%b need %h 0",
               act_all, bus.DI_RDY, exp_all());
    end
    @(negedge QCK);
    checks++;
    if ({DONE, ERR, CFG_VALID} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_flags got %b need 000",
               {DONE, ERR, CFG_VALID});
    end
    @(posedge QCK);
    #1 QRT = 1'b1;
    d0 = done_cnt;
    gen_random();
    send_frame(8'h00, 1);
    model_commit();
    repeat (3) @(negedge QCK);
    checks++;
    if (act_all !== exp_all() || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL post_reset got %h done=%0d need %h 1",
               act_all, done_cnt - d0, exp_all());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_garbage();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
